// File: rtl/clk_div_sched.sv
// Programmable clock divider with a one-deep ratio slot fed by two round-robin requesters.
// Optional macro CLK_DIV_SCHED_ERR_EN: reject zero ratios with an err pulse instead of clamping them to 1.
module clk_div_sched #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             req_a_valid,
  input  logic [CNT_W-1:0] req_a_div,
  output logic             req_a_ready,
  input  logic             req_b_valid,
  input  logic [CNT_W-1:0] req_b_div,
  output logic             req_b_ready,
  output logic             result,
  output logic             tick,
  output logic [CNT_W-1:0] cur_div,
  output logic             pend,
  output logic             err
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] slot;
  logic             prio_b;
  logic             grant_a;
  logic             grant_b;
  logic             xfer;
  logic [CNT_W-1:0] xfer_div;
  logic             wrap;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    if (!reset && !pend) begin
      grant_a = req_a_valid && (!req_b_valid || !prio_b);
      grant_b = req_b_valid && (!req_a_valid ||  prio_b);
    end
    xfer     = grant_a || grant_b;
    xfer_div = grant_a ? req_a_div : req_b_div;
    // cur_div is never zero, so cur_div-1 cannot underflow and the max ratio still fits.
    wrap     = (count == cur_div - ONE);
  end

  assign req_a_ready = grant_a;
  assign req_b_ready = grant_b;

`ifndef CLK_DIV_SCHED_ERR_EN
  assign err = 1'b0;
`endif

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      result  <= 1'b0;
      tick    <= 1'b0;
      cur_div <= CNT_W'(DEFAULT_DIV);
      pend    <= 1'b0;
      slot    <= '0;
      prio_b  <= 1'b0;
`ifdef CLK_DIV_SCHED_ERR_EN
      err     <= 1'b0;
`endif
    end else begin
      tick  <= 1'b0;
`ifdef CLK_DIV_SCHED_ERR_EN
      err   <= 1'b0;
`endif
      state <= run ? ST_RUN : ST_IDLE;

      if (state == ST_IDLE && pend) begin
        // While stopped there is no period to protect, so apply right away.
        cur_div <= slot;
        pend    <= 1'b0;
        count   <= '0;
        result  <= 1'b0;
      end else if (!run) begin
        count  <= '0;
        result <= 1'b0;
      end else if (wrap) begin
        count  <= '0;
        result <= ~result;
        tick   <= 1'b1;
        if (pend) begin
          cur_div <= slot;
          pend    <= 1'b0;
        end
      end else begin
        count <= count + ONE;
      end

      // A transfer only happens with the slot empty, so it never collides with an apply.
      if (xfer) begin
        prio_b <= grant_a;
`ifdef CLK_DIV_SCHED_ERR_EN
        if (xfer_div == '0) begin
          err <= 1'b1;
        end else begin
          slot <= xfer_div;
          pend <= 1'b1;
        end
`else
        slot <= (xfer_div == '0) ? ONE : xfer_div;
        pend <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: doc/clk_div_sched.md
CLK_DIV_SCHED -- requirements
Module: clk_div_sched

Interface
REQ-001 Parameter CNT_W, default 8, width of divide-ratio fields and the half-period counter.
REQ-002 Parameter DEFAULT_DIV, default 3, half-period length in clk cycles loaded at reset.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 run  input  1  1 = divider running, 0 = divider stopped (IDLE).
REQ-006 req_a_valid  input  1  requester A offers a new ratio.
REQ-007 req_a_div  input  CNT_W  requester A half-period ratio.
REQ-008 req_a_ready  output  1  requester A transfer accepted this cycle.
REQ-009 req_b_valid / req_b_div / req_b_ready  same as REQ-006..008, for requester B.
REQ-010 result  output  1  divided clock, registered.
REQ-011 tick  output  1  one-cycle pulse on every result toggle.
REQ-012 cur_div  output  CNT_W  ratio currently in effect.
REQ-013 pend  output  1  a ratio is held in the pending slot.
REQ-014 err  output  1  one-cycle pulse on a rejected zero ratio (macro-dependent, REQ-032).

Function
REQ-015 States: IDLE (run=0) and RUN (run=1); IDLE->RUN on the first edge with run=1, RUN->IDLE on the first edge with run=0.
REQ-016 IDLE: counter forced to 0, result forced to 0, tick 0.
REQ-017 RUN: counter increments each cycle; when counter==cur_div-1 it wraps to 0, result toggles and tick=1 in the cycle the new result is visible.
REQ-018 Output period in RUN = 2*cur_div clk cycles; cur_div=1 gives result toggling every cycle.
REQ-019 Pending slot one entry deep; req_x_ready asserted only while slot empty and x is the granted requester.
REQ-020 Arbitration round-robin: if both valid with slot empty, grant the requester not granted last; after reset A has priority.
REQ-021 Only one transfer per cycle; a valid not granted holds until granted, with no data loss.
REQ-022 Transfer on edge with valid&&ready: slot loaded, pend=1 from next cycle.
REQ-023 RUN: pending ratio applied at the next wrap edge (cur_div<=slot, counter<=0, pend<=0); never mid-period.
REQ-024 Transfer on the same edge as a wrap: applied at the following wrap, not the current one.
REQ-025 IDLE: pending ratio applied on the edge after the transfer.
REQ-026 Slot empties on the apply edge; ready may assert in the next cycle.
REQ-027 run dropped mid-period: next edge enters IDLE, result=0, counter=0; cur_div and pending slot retained.
REQ-028 Ratio arithmetic unsigned CNT_W bits; counter compare uses cur_div-1 with no overflow for cur_div = 2^CNT_W-1.

Reset
REQ-029 On reset: result=0, tick=0, err=0, counter=0, cur_div=DEFAULT_DIV, pend=0, round-robin pointer favours A, state IDLE.
REQ-030 Reset overrides run, requests and any in-progress period or handshake; no transfer completes on a reset edge.

Configuration
REQ-031 Macro CLK_DIV_SCHED_ERR_EN selects zero-ratio handling.
REQ-032 Defined: a transfer with div==0 is accepted (ready=1), discarded, slot unchanged, err pulses one cycle. Undefined: div==0 stored and applied as 1, err tied to 0.

Verification
REQ-033 Reset, run=1, no requests -> result period 6 clk, tick every 3 clk, cur_div=3.
REQ-034 RUN with cur_div=3, A sends 5 mid-period -> pend=1, current half-period finishes at 3, then half-periods of 5; pend=0 after apply.
REQ-035 A and B both valid (4, 7) every cycle from reset -> A granted first, B next after slot empties, then alternating.
REQ-036 Transfer of 2 exactly on a wrap edge -> next half-period still uses old ratio, then 2.
REQ-037 run dropped mid-period with pending 6 -> result=0 next cycle; pending applied in IDLE; run re-raised -> first toggle after 6 clk.
REQ-038 B sends div=0 -> with CLK_DIV_SCHED_ERR_EN: err pulse, cur_div unchanged; without: cur_div becomes 1, result toggles every clk.
